// File: rtl/bakraid_sdram_pkg.sv
// Shared types and constants for the Bakraid SDRAM arbiter.
package bakraid_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDATA,
    WDONE
  } state_t;

  localparam int unsigned BURST_DEF = 2;
  localparam int unsigned SDRAM_AW  = 22;

  localparam logic [1:0] BANK_PRG  = 2'd0;
  localparam logic [1:0] BANK_GFX0 = 2'd1;
  localparam logic [1:0] BANK_GFX1 = 2'd2;
  localparam logic [1:0] BANK_PCM  = 2'd3;

endpackage

// File: rtl/bakraid_rr_pick4.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo 4.
module bakraid_rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!valid && req[ptr + 2'(i)]) begin
        valid = 1'b1;
        idx   = ptr + 2'(i);
      end
    end
  end

endmodule

// File: rtl/bakraid_sdram_arb.sv
// Arbitrates four bank readers and the ROM loader onto one SDRAM command port.
module bakraid_sdram_arb
  import bakraid_sdram_pkg::*;
#(
  parameter int unsigned BURST = BURST_DEF,
  parameter int unsigned AW    = SDRAM_AW
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          DOWNLOADING,
  input  logic          PROG_WE,
  input  logic [AW-1:0] PROG_ADDR,
  input  logic [1:0]    PROG_BA,
  input  logic [15:0]   PROG_DATA,
  input  logic [1:0]    PROG_MASK,
  output logic          PROG_RDY,
  input  logic [AW-1:0] BA0_ADDR,
  input  logic [AW-1:0] BA1_ADDR,
  input  logic [AW-1:0] BA2_ADDR,
  input  logic [AW-1:0] BA3_ADDR,
  input  logic [3:0]    BA_RD,
  output logic [3:0]    BA_ACK,
  output logic [3:0]    BA_DST,
  output logic [3:0]    BA_DOK,
  output logic [3:0]    BA_RDY,
  output logic [15:0]   DATA_READ,
  output logic          CMD_REQ,
  output logic          CMD_WE,
  output logic [1:0]    CMD_BA,
  output logic [AW-1:0] CMD_ADDR,
  output logic [15:0]   CMD_DIN,
  output logic [1:0]    CMD_MASK,
  input  logic          CMD_ACK,
  input  logic          CMD_DOK,
  input  logic [15:0]   CMD_DATA
);

  localparam logic [1:0] LAST = 2'(BURST - 1);

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    cnt;
  logic          pick_valid;
  logic [1:0]    pick_idx;
  logic [AW-1:0] rd_addr;
  logic [3:0]    sel;

  bakraid_rr_pick4 u_pick (
    .req   (BA_RD),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    rd_addr = BA0_ADDR;
    case (pick_idx)
      2'd1:    rd_addr = BA1_ADDR;
      2'd2:    rd_addr = BA2_ADDR;
      2'd3:    rd_addr = BA3_ADDR;
      default: rd_addr = BA0_ADDR;
    endcase
  end

  // CMD_BA holds the granted bank for the whole read, so it steers the handshakes.
  always_comb sel = 4'b0001 << CMD_BA;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      CMD_REQ   <= 1'b0;
      CMD_WE    <= 1'b0;
      CMD_BA    <= '0;
      CMD_ADDR  <= '0;
      CMD_DIN   <= '0;
      CMD_MASK  <= '0;
      BA_ACK    <= '0;
      BA_DST    <= '0;
      BA_DOK    <= '0;
      BA_RDY    <= '0;
      DATA_READ <= '0;
      PROG_RDY  <= 1'b0;
    end else begin
      BA_ACK   <= '0;
      BA_DST   <= '0;
      BA_DOK   <= '0;
      BA_RDY   <= '0;
      PROG_RDY <= 1'b0;
      case (state)
        IDLE: begin
          if (DOWNLOADING) begin
            if (PROG_WE) begin
              CMD_ADDR <= PROG_ADDR;
              CMD_BA   <= PROG_BA;
              CMD_DIN  <= PROG_DATA;
              CMD_MASK <= PROG_MASK;
              CMD_WE   <= 1'b1;
              CMD_REQ  <= 1'b1;
              state    <= CMD;
            end
          end else if (pick_valid) begin
            CMD_ADDR <= rd_addr;
            CMD_BA   <= pick_idx;
            CMD_WE   <= 1'b0;
            CMD_REQ  <= 1'b1;
            ptr      <= pick_idx + 2'd1;
            cnt      <= '0;
            state    <= CMD;
          end
        end
        CMD: begin
          if (CMD_ACK) begin
            CMD_REQ <= 1'b0;
            if (CMD_WE) begin
              state <= WDONE;
            end else begin
              BA_ACK <= sel;
              state  <= RDATA;
            end
          end
        end
        RDATA: begin
          if (CMD_DOK) begin
            DATA_READ <= CMD_DATA;
            BA_DOK    <= sel;
            if (cnt == '0) BA_DST <= sel;
            if (cnt == LAST) begin
              BA_RDY <= sel;
              cnt    <= '0;
              state  <= IDLE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        WDONE: begin
          if (CMD_DOK) begin
            PROG_RDY <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bakraid_sdram_arb.sv
// Scoreboard bench for bakraid_sdram_arb: expected handshake events queued at stimulus time.
module tb_bakraid_sdram_arb;

  typedef struct packed {
    logic [3:0]  ack;
    logic [3:0]  dst;
    logic [3:0]  dok;
    logic [3:0]  rdy;
    logic        prog;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, dl, prog_we, prog_rdy;
  logic [21:0] prog_addr;
  logic [1:0]  prog_ba, prog_mask;
  logic [15:0] prog_data;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]  ba_rd, ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0] data_read;
  logic        cmd_req, cmd_we, cmd_ack, cmd_dok;
  logic [1:0]  cmd_ba, cmd_mask;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_din, cmd_data;

  logic [3:0]  b1_rd, b1_bk_ack, b1_dst, b1_dok, b1_rdy;
  logic        b1_req, b1_we, b1_ack, b1_cdok, b1_prdy;
  logic [1:0]  b1_ba, b1_mask;
  logic [21:0] b1_addr;
  logic [15:0] b1_din, b1_data, b1_read;

  int   n_chk = 0;
  int   n_err = 0;
  ev_t  q[$];

  always #5 clk = ~clk;

  bakraid_sdram_arb u_dut (
    .CLK(clk), .RESET(rst), .DOWNLOADING(dl),
    .PROG_WE(prog_we), .PROG_ADDR(prog_addr), .PROG_BA(prog_ba),
    .PROG_DATA(prog_data), .PROG_MASK(prog_mask), .PROG_RDY(prog_rdy),
    .BA0_ADDR(ba0_addr), .BA1_ADDR(ba1_addr), .BA2_ADDR(ba2_addr), .BA3_ADDR(ba3_addr),
    .BA_RD(ba_rd), .BA_ACK(ba_ack), .BA_DST(ba_dst), .BA_DOK(ba_dok), .BA_RDY(ba_rdy),
    .DATA_READ(data_read), .CMD_REQ(cmd_req), .CMD_WE(cmd_we), .CMD_BA(cmd_ba),
    .CMD_ADDR(cmd_addr), .CMD_DIN(cmd_din), .CMD_MASK(cmd_mask),
    .CMD_ACK(cmd_ack), .CMD_DOK(cmd_dok), .CMD_DATA(cmd_data)
  );

  bakraid_sdram_arb #(.BURST(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .DOWNLOADING(1'b0),
    .PROG_WE(1'b0), .PROG_ADDR(22'd0), .PROG_BA(2'd0),
    .PROG_DATA(16'd0), .PROG_MASK(2'd0), .PROG_RDY(b1_prdy),
    .BA0_ADDR(ba0_addr), .BA1_ADDR(ba1_addr), .BA2_ADDR(ba2_addr), .BA3_ADDR(ba3_addr),
    .BA_RD(b1_rd), .BA_ACK(b1_bk_ack), .BA_DST(b1_dst), .BA_DOK(b1_dok), .BA_RDY(b1_rdy),
    .DATA_READ(b1_read), .CMD_REQ(b1_req), .CMD_WE(b1_we), .CMD_BA(b1_ba),
    .CMD_ADDR(b1_addr), .CMD_DIN(b1_din), .CMD_MASK(b1_mask),
    .CMD_ACK(b1_ack), .CMD_DOK(b1_cdok), .CMD_DATA(b1_data)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ev_t mk(input logic [3:0] a, input logic [3:0] s, input logic [3:0] k,
                             input logic [3:0] r, input logic p, input logic [15:0] d);
    ev_t e;
    e.ack = a; e.dst = s; e.dok = k; e.rdy = r; e.prog = p; e.data = d;
    return e;
  endfunction

  function automatic logic [21:0] addr_of(input logic [1:0] b);
    case (b)
      2'd0:    return 22'h000100;
      2'd1:    return 22'h011200;
      2'd2:    return 22'h022300;
      default: return 22'h033400;
    endcase
  endfunction

  // Every pulse cycle on the main DUT must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t obs, e;
    obs = mk(ba_ack, ba_dst, ba_dok, ba_rdy, prog_rdy, (|ba_dok) ? data_read : 16'd0);
    if (obs != '0) begin
      if (q.size() == 0) begin
        chk("unexpected_evt", 96'(obs), 96'd0);
      end else begin
        e = q.pop_front();
        chk("evt", 96'(obs), 96'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_req && n < 20);
    if (!cmd_req) chk("req_timeout", 96'd0, 96'd1);
  endtask

  task automatic do_read(input logic [1:0] bank, input bit spur, input bit drop_cmd,
                         input bit release_rd);
    int          n;
    logic [3:0]  oh;
    logic [15:0] d;
    oh = 4'b0001 << bank;
    wait_req(n);
    if (!cmd_req) return;
    chk("rd_latency", 96'(n), 96'd1);
    chk("rd_we", 96'(cmd_we), 96'd0);
    chk("rd_ba", 96'(cmd_ba), 96'(bank));
    chk("rd_addr", 96'(cmd_addr), 96'(addr_of(bank)));
    if (drop_cmd) ba_rd[bank] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmd_ack = 1'b1;
    q.push_back(mk(oh, 4'd0, 4'd0, 4'd0, 1'b0, 16'd0));
    @(negedge clk);
    cmd_ack = 1'b0;
    if (release_rd) ba_rd[bank] = 1'b0;
    if (spur) begin
      cmd_ack = 1'b1;
      @(negedge clk);
      cmd_ack = 1'b0;
    end
    for (int w = 0; w < 2; w++) begin
      d = 16'($urandom);
      cmd_dok  = 1'b1;
      cmd_data = d;
      q.push_back(mk(4'd0, (w == 0) ? oh : 4'd0, oh, (w == 1) ? oh : 4'd0, 1'b0, d));
      @(negedge clk);
    end
    cmd_dok = 1'b0;
  endtask

  initial begin
    int          n;
    bit          saw;
    logic [15:0] d;
    rst = 1'b1; dl = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_ba = '0;
    prog_data = '0; prog_mask = '0; ba_rd = '0; cmd_ack = 1'b0; cmd_dok = 1'b0;
    cmd_data = '0; b1_rd = '0; b1_ack = 1'b0; b1_cdok = 1'b0; b1_data = '0;
    ba0_addr = addr_of(2'd0); ba1_addr = addr_of(2'd1);
    ba2_addr = addr_of(2'd2); ba3_addr = addr_of(2'd3);
    repeat (3) @(negedge clk);
    chk("reset_cmd", {cmd_req, cmd_we, cmd_ba, cmd_addr, cmd_din, cmd_mask}, 96'd0);
    chk("reset_bank", {prog_rdy, ba_ack, ba_dst, ba_dok, ba_rdy, data_read}, 96'd0);
    chk("reset_b1", {b1_req, b1_bk_ack, b1_dst, b1_dok, b1_rdy, b1_read}, 96'd0);
    rst = 1'b0;
    @(negedge clk);

    // All four banks requesting continuously: grants 0,1,2,3,0.
    ba_rd = 4'b1111;
    do_read(2'd0, 1'b0, 1'b0, 1'b0);
    do_read(2'd1, 1'b0, 1'b0, 1'b0);
    do_read(2'd2, 1'b0, 1'b0, 1'b0);
    do_read(2'd3, 1'b0, 1'b0, 1'b0);
    do_read(2'd0, 1'b0, 1'b0, 1'b0);
    ba_rd = 4'b0000;

    // Reset after the first word of a bank 1 read; pointer must return to 0.
    ba_rd = 4'b0010;
    wait_req(n);
    chk("rst_rd_ba", 96'(cmd_ba), 96'd1);
    @(negedge clk);
    @(negedge clk);
    cmd_ack = 1'b1;
    q.push_back(mk(4'b0010, 4'd0, 4'd0, 4'd0, 1'b0, 16'd0));
    @(negedge clk);
    cmd_ack = 1'b0;
    ba_rd = 4'b0000;
    d = 16'h1357;
    cmd_dok = 1'b1; cmd_data = d;
    q.push_back(mk(4'd0, 4'b0010, 4'b0010, 4'd0, 1'b0, d));
    @(negedge clk);
    rst = 1'b1;
    cmd_data = 16'h2468;
    @(negedge clk);
    cmd_dok = 1'b0;
    chk("midrst_cmd", {cmd_req, cmd_we, cmd_ba, cmd_addr, cmd_din, cmd_mask}, 96'd0);
    chk("midrst_bank", {prog_rdy, ba_ack, ba_dst, ba_dok, ba_rdy, data_read}, 96'd0);
    rst = 1'b0;
    ba_rd = 4'b1001;
    do_read(2'd0, 1'b0, 1'b0, 1'b1);
    do_read(2'd3, 1'b0, 1'b0, 1'b1);

    // Bank 3 drops its request while in CMD; spurious ACK arrives during RDATA.
    ba_rd = 4'b1000;
    do_read(2'd3, 1'b1, 1'b1, 1'b0);
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw |= cmd_req;
    end
    chk("no_reissue", 96'(saw), 96'd0);

    // Spurious CMD_DOK in IDLE, then a normal read still works.
    cmd_dok = 1'b1; cmd_data = 16'hDEAD;
    @(negedge clk);
    cmd_dok = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_dok_req", 96'(cmd_req), 96'd0);
    ba_rd = 4'b0100;
    do_read(2'd2, 1'b0, 1'b0, 1'b1);

    // Loader write with a bank 0 read pending.
    dl = 1'b1; ba_rd = 4'b0001;
    prog_we = 1'b1; prog_addr = 22'h100000; prog_ba = 2'd2;
    prog_data = 16'hA5A5; prog_mask = 2'b10;
    wait_req(n);
    chk("wr_latency", 96'(n), 96'd1);
    chk("wr_we", 96'(cmd_we), 96'd1);
    chk("wr_ba", 96'(cmd_ba), 96'd2);
    chk("wr_addr", 96'(cmd_addr), 96'h100000);
    chk("wr_din", 96'(cmd_din), 96'hA5A5);
    chk("wr_mask", 96'(cmd_mask), 96'd2);
    @(negedge clk);
    @(negedge clk);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    cmd_dok = 1'b1;
    q.push_back(mk(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 16'd0));
    @(negedge clk);
    cmd_dok = 1'b0;
    // Loader leaves while PROG_WE is still high: the write must not restart.
    dl = 1'b0; ba_rd = 4'b0000;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw |= cmd_req;
    end
    chk("no_write_after_dl", 96'(saw), 96'd0);
    prog_we = 1'b0;

    // BURST = 1 instance: DST and RDY coincide on the single word.
    b1_rd = 4'b0010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b1_req && n < 20);
    chk("b1_req", 96'(b1_req), 96'd1);
    chk("b1_ba", 96'(b1_ba), 96'd1);
    b1_ack = 1'b1;
    @(negedge clk);
    b1_ack = 1'b0;
    b1_rd = 4'b0000;
    chk("b1_ack", 96'(b1_bk_ack), 96'b0010);
    b1_cdok = 1'b1; b1_data = 16'h5AA5;
    @(negedge clk);
    b1_cdok = 1'b0;
    chk("b1_word", {b1_dst, b1_dok, b1_rdy, b1_read}, {4'b0010, 4'b0010, 4'b0010, 16'h5AA5});
    @(negedge clk);
    chk("b1_after", {b1_dst, b1_dok, b1_rdy, b1_req}, 96'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 96'(q.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
